vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-006 SHALL have port CLK_IN input 1, system clock; one clock only.
REQ-007 SHALL have port RESET_N input 1, synchronous, active-low reset.
REQ-008 SHALL have port PIX_EN input 1, pixel-rate enable (one CLK_IN cycle per pixel).
REQ-009 SHALL have ports HSYNC and VSYNC output 1 each, sync pulses at SYNC_POL level when active.
REQ-010 SHALL have port ACTIVE output 1, high inside the visible area.
REQ-011 SHALL have ports PIXEL_X and PIXEL_Y output 10 each, current horizontal and vertical counts.
REQ-012 SHALL have ports LINE_START and FRAME_START output 1 each, single-cycle position pulses.

Function
REQ-013 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525); both computed at elaboration.
REQ-014 Counters SHALL advance only on CLK_IN edges with PIX_EN=1; with PIX_EN=0 every output except the pulses holds.
REQ-015 H count SHALL increment; at H_TOTAL-1 it wraps to 0 and V increments; V wraps to 0 at V_TOTAL-1 coincident with H wrap.
REQ-016 ACTIVE = (H<H_ACTIVE)&&(V<V_ACTIVE).
REQ-017 HSYNC active iff H_ACTIVE+H_FP <= H < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-018 VSYNC active iff V_ACTIVE+V_FP <= V < V_ACTIVE+V_FP+V_SYNC (490..491); changes only with H wrap.
REQ-019 All outputs SHALL be registered and updated on the same edge as the counters, so PIXEL_X/Y, ACTIVE, HSYNC, VSYNC always agree (zero skew, no combinational decode at ports).
REQ-020 LINE_START SHALL be high for exactly one CLK_IN cycle after the edge that moves H to 0.
REQ-021 FRAME_START SHALL be high for exactly one CLK_IN cycle after the edge that moves (H,V) to (0,0); LINE_START also pulses then.
REQ-022 PIX_EN asserted continuously SHALL produce exactly H_TOTAL*V_TOTAL cycles per frame.

Reset
REQ-023 While RESET_N=0 at a CLK_IN edge: H=H_TOTAL-1, V=V_TOTAL-1, PIXEL_X=799, PIXEL_Y=524, ACTIVE=0, HSYNC=VSYNC=inactive, LINE_START=FRAME_START=0.
REQ-024 First PIX_EN after reset release SHALL move to (0,0) and pulse FRAME_START.
REQ-025 Reset mid-frame SHALL abandon the frame immediately, no partial sync pulse continues.
REQ-026 RESET_N low takes priority over PIX_EN on the same edge.

Configuration
REQ-027 Macro VGA_TIMING_FRAME_CNT_EN defined: add output FRAME_CNT, 16 bits, reset 0, incremented on each wrap to (0,0), wraps 65535->0.
REQ-028 Macro undefined: no FRAME_CNT port, no counter logic; all other behaviour identical.

Structure
REQ-029 Shared package vga_pkg SHALL hold 640x480@60 timing constants, H_TOTAL/V_TOTAL functions and coordinate width constant (10).
REQ-030 One sub-module vga_axis_counter (count, wrap, sync/active window decode), instantiated once horizontal, once vertical with vertical step = horizontal wrap.

Verification
REQ-031 Reset 5 cycles, then PIX_EN=1 constant -> FRAME_START one cycle after first enabled edge; PIXEL_X=0, PIXEL_Y=0, ACTIVE=1.
REQ-032 PIX_EN every 2nd cycle -> HSYNC low for 192 CLK_IN cycles, starting when PIXEL_X=656; period 1600 cycles.
REQ-033 Full frame, PIX_EN=1 -> FRAME_START period 420000 cycles; VSYNC low 1600 cycles at PIXEL_Y 490..491; ACTIVE high 307200 cycles.
REQ-034 RESET_N low at PIXEL_X=700, PIXEL_Y=300 -> next cycle values 799/524, HSYNC=VSYNC=1, ACTIVE=0.
REQ-035 PIX_EN held 0 for 50 cycles at PIXEL_X=655 -> all outputs frozen, LINE_START/FRAME_START 0; resumes at 656 with HSYNC low.
REQ-036 With VGA_TIMING_FRAME_CNT_EN, 3 frames -> FRAME_CNT=3; forced to 65535 then one wrap -> 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, line/frame total helpers and
// the coordinate width used by every block of the VGA timing generator.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // 640x480@60 horizontal timing, in pixels.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // 640x480@60 vertical timing, in lines.
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Pixels per line, including blanking.
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Lines per frame, including blanking.
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: bundle of the pixel-rate enable and the timing outputs.
// The master side is the timing generator, the slave side is the pixel sink.
interface vga_timing_gen_if
  import vga_pkg::*;
(
  input logic clk
);

  logic   pix_en;
  logic   hsync;
  logic   vsync;
  logic   active;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   line_start;
  logic   frame_start;

  modport master (
    input  clk,
    input  pix_en,
    output hsync,
    output vsync,
    output active,
    output pixel_x,
    output pixel_y,
    output line_start,
    output frame_start
  );

  modport slave (
    input  clk,
    output pix_en,
    input  hsync,
    input  vsync,
    input  active,
    input  pixel_x,
    input  pixel_y,
    input  line_start,
    input  frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical). Counts 0..TOTAL-1
// on each step, flags the wrap, and registers the sync window decode of the
// new count so sync and count change on the same edge.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 752,
  parameter int SYNC_POL   = 0
) (
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   step_i,
  output coord_t count_o,
  output logic   wrap_o,
  output logic   sync_o,
  output logic   active_nxt_o
);

  localparam coord_t LAST    = coord_t'(TOTAL - 1);
  localparam coord_t ACT_END = coord_t'(ACTIVE);
  localparam coord_t SYNC_LO = coord_t'(SYNC_START);
  localparam coord_t SYNC_HI = coord_t'(SYNC_END);
  localparam logic   SYNC_ON = (SYNC_POL != 0);

  coord_t count_q, count_d;
  logic   sync_q, sync_d;

  // The step that moves the count from LAST back to zero; drives the next axis.
  assign wrap_o = step_i && (count_q == LAST);

  // Next count and the sync decode of that next count.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    count_d = count_q;
    if (step_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + coord_t'(1);
    end
    sync_d = ((count_d >= SYNC_LO) && (count_d < SYNC_HI)) ? SYNC_ON : ~SYNC_ON;
  end

  // Visible-window flag of the next count, registered by the top together
  // with the other axis so ACTIVE lines up with the counts.
  assign active_nxt_o = (count_d < ACT_END);

  // Count and sync registers; reset parks the axis on its last position.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n_i) begin
      count_q <= LAST;
      sync_q  <= ~SYNC_ON;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator. A horizontal axis counter steps
// on PIX_EN and a vertical one steps on the horizontal wrap; every output is a
// register so counts, syncs and ACTIVE change on the same edge.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit FRAME_CNT
// output counting wraps to (0,0).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int SYNC_POL = 0
) (
  input  logic        CLK_IN,
  input  logic        RESET_N,
  input  logic        PIX_EN,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        ACTIVE,
  output coord_t      PIXEL_X,
  output coord_t      PIXEL_Y,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic [15:0] FRAME_CNT,
`endif
  output logic        LINE_START,
  output logic        FRAME_START
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic h_wrap, v_wrap;
  logic h_act_nxt, v_act_nxt;
  logic active_q, line_start_q, frame_start_q;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .clk_i        (CLK_IN),
    .rst_n_i      (RESET_N),
    .step_i       (PIX_EN),
    .count_o      (PIXEL_X),
    .wrap_o       (h_wrap),
    .sync_o       (HSYNC),
    .active_nxt_o (h_act_nxt)
  );

  // The vertical axis advances once per line, on the horizontal wrap.
  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .clk_i        (CLK_IN),
    .rst_n_i      (RESET_N),
    .step_i       (h_wrap),
    .count_o      (PIXEL_Y),
    .wrap_o       (v_wrap),
    .sync_o       (VSYNC),
    .active_nxt_o (v_act_nxt)
  );

  // Visible flag and position pulses, registered alongside the counts.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      active_q      <= h_act_nxt && v_act_nxt;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign ACTIVE      = active_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter; rolls over from 65535 to 0.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign FRAME_CNT = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two instances share one clock. dut0 uses the default
// 640x480 timing for line-level checks; dut1 uses a tiny raster with
// active-high sync so whole frames fit in a short run. A cycle model per
// instance pushes the expected output vector on every rising edge and the
// scoreboard pops and compares it on the falling edge.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int   S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int   S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam logic S_POL = 1'b1;

  int   cfg_ha [2] = '{640, S_HA};
  int   cfg_hf [2] = '{16,  S_HF};
  int   cfg_hs [2] = '{96,  S_HS};
  int   cfg_ht [2] = '{800, S_HA + S_HF + S_HS + S_HB};
  int   cfg_va [2] = '{480, S_VA};
  int   cfg_vf [2] = '{10,  S_VF};
  int   cfg_vs [2] = '{2,   S_VS};
  int   cfg_vt [2] = '{525, S_VA + S_VF + S_VS + S_VB};
  logic cfg_pol[2] = '{1'b0, S_POL};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if vif (.clk(clk));

  logic   rst0_n, rst1_n, en1;
  logic   hs1, vs1, act1, ls1, fs1;
  coord_t x1, y1;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc0, fc1;
`endif

  vga_timing_gen dut0 (
    .CLK_IN      (clk),
    .RESET_N     (rst0_n),
    .PIX_EN      (vif.pix_en),
    .HSYNC       (vif.hsync),
    .VSYNC       (vif.vsync),
    .ACTIVE      (vif.active),
    .PIXEL_X     (vif.pixel_x),
    .PIXEL_Y     (vif.pixel_y),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .FRAME_CNT   (fc0),
`endif
    .LINE_START  (vif.line_start),
    .FRAME_START (vif.frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .SYNC_POL (1)
  ) dut1 (
    .CLK_IN      (clk),
    .RESET_N     (rst1_n),
    .PIX_EN      (en1),
    .HSYNC       (hs1),
    .VSYNC       (vs1),
    .ACTIVE      (act1),
    .PIXEL_X     (x1),
    .PIXEL_Y     (y1),
`ifdef VGA_TIMING_FRAME_CNT_EN
    .FRAME_CNT   (fc1),
`endif
    .LINE_START  (ls1),
    .FRAME_START (fs1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          mh[2];
  int          mv[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Expected vector {pad, x, y, hsync, vsync, active, line_start, frame_start}.
  function automatic logic [31:0] exp_vec(input int d, input int h, input int v,
                                          input logic ls, input logic fs);
    logic hs_on, vs_on, act;
    hs_on = (h >= cfg_ha[d] + cfg_hf[d]) && (h < cfg_ha[d] + cfg_hf[d] + cfg_hs[d]);
    vs_on = (v >= cfg_va[d] + cfg_vf[d]) && (v < cfg_va[d] + cfg_vf[d] + cfg_vs[d]);
    act   = (h < cfg_ha[d]) && (v < cfg_va[d]);
    return {7'd0, h[9:0], v[9:0], hs_on ? cfg_pol[d] : ~cfg_pol[d],
            vs_on ? cfg_pol[d] : ~cfg_pol[d], act, ls, fs};
  endfunction

  task automatic model_step(input int d, input logic rn, input logic en);
    logic ls, fs;
    ls = 1'b0;
    fs = 1'b0;
    if (!rn) begin
      mh[d] = cfg_ht[d] - 1;
      mv[d] = cfg_vt[d] - 1;
    end else if (en) begin
      if (mh[d] == cfg_ht[d] - 1) begin
        mh[d] = 0;
        ls    = 1'b1;
        if (mv[d] == cfg_vt[d] - 1) begin
          mv[d] = 0;
          fs    = 1'b1;
        end else begin
          mv[d] = mv[d] + 1;
        end
      end else begin
        mh[d] = mh[d] + 1;
      end
    end
    if (d == 0) q0.push_back(exp_vec(d, mh[d], mv[d], ls, fs));
    else        q1.push_back(exp_vec(d, mh[d], mv[d], ls, fs));
  endtask

  always @(posedge clk) begin
    model_step(0, rst0_n, vif.pix_en);
    model_step(1, rst1_n, en1);
  end

  always @(negedge clk) begin
    if (q0.size() > 0)
      check("sb0", {7'd0, vif.pixel_x, vif.pixel_y, vif.hsync, vif.vsync, vif.active,
                    vif.line_start, vif.frame_start}, q0.pop_front());
    if (q1.size() > 0)
      check("sb1", {7'd0, x1, y1, hs1, vs1, act1, ls1, fs1}, q1.pop_front());
  end

  logic found, pulse_seen, prev_hs, hs_now;
  int   fall1, fall2, x_at_fall, low_cnt;
  int   fs_seen, f_cnt, f_vs, f_act, f_ls, f_vy;

  initial begin
    rst0_n     = 1'b0;
    rst1_n     = 1'b0;
    vif.pix_en = 1'b0;
    en1        = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state of the default-timing instance.
    check("rst_x",   32'(vif.pixel_x), 32'd799);
    check("rst_y",   32'(vif.pixel_y), 32'd524);
    check("rst_hs",  32'(vif.hsync),   32'd1);
    check("rst_vs",  32'(vif.vsync),   32'd1);
    check("rst_act", 32'(vif.active),  32'd0);
    check("rst_fs",  32'(vif.frame_start), 32'd0);

    // First enabled edge lands on (0,0) with a frame start.
    rst0_n     = 1'b1;
    rst1_n     = 1'b1;
    vif.pix_en = 1'b1;
    en1        = 1'b1;
    @(negedge clk);
    check("first_fs",  32'(vif.frame_start), 32'd1);
    check("first_ls",  32'(vif.line_start),  32'd1);
    check("first_x",   32'(vif.pixel_x),     32'd0);
    check("first_y",   32'(vif.pixel_y),     32'd0);
    check("first_act", 32'(vif.active),      32'd1);
    @(negedge clk);
    check("fs_single", 32'(vif.frame_start), 32'd0);
    check("second_x",  32'(vif.pixel_x),     32'd1);

    // Freeze just before the horizontal sync window.
    found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (vif.pixel_x == 10'd655) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_x655", 32'(found), 32'd1);
    vif.pix_en = 1'b0;
    pulse_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (vif.line_start || vif.frame_start) pulse_seen = 1'b1;
    end
    check("frz_x",     32'(vif.pixel_x), 32'd655);
    check("frz_hs",    32'(vif.hsync),   32'd1);
    check("frz_pulse", 32'(pulse_seen),  32'd0);
    vif.pix_en = 1'b1;
    @(negedge clk);
    check("resume_x",  32'(vif.pixel_x), 32'd656);
    check("resume_hs", 32'(vif.hsync),   32'd0);

    // Half-rate pixel enable: measure the horizontal sync pulse.
    fall1 = -1; fall2 = -1; x_at_fall = -1; low_cnt = 0;
    prev_hs = vif.hsync;
    for (int c = 0; c < 4000; c++) begin
      vif.pix_en = ~vif.pix_en;
      @(negedge clk);
      hs_now = vif.hsync;
      if (prev_hs && !hs_now) begin
        if (fall1 < 0) begin
          fall1     = c;
          x_at_fall = int'(vif.pixel_x);
        end else if (fall2 < 0) begin
          fall2 = c;
        end
      end
      if (!hs_now && fall1 >= 0 && fall2 < 0) low_cnt++;
      prev_hs = hs_now;
    end
    vif.pix_en = 1'b1;
    check("hs_found",  32'(fall2 >= 0),     32'd1);
    check("hs_x_fall", 32'(x_at_fall),      32'd656);
    check("hs_low",    32'(low_cnt),        32'd192);
    check("hs_period", 32'(fall2 - fall1),  32'd1600);

    // Mid-line reset of the default instance inside its sync pulse.
    found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (vif.pixel_x == 10'd700) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_x700", 32'(found), 32'd1);
    rst0_n = 1'b0;
    @(negedge clk);
    check("mr0_x",   32'(vif.pixel_x), 32'd799);
    check("mr0_y",   32'(vif.pixel_y), 32'd524);
    check("mr0_hs",  32'(vif.hsync),   32'd1);
    check("mr0_vs",  32'(vif.vsync),   32'd1);
    check("mr0_act", 32'(vif.active),  32'd0);
    rst0_n = 1'b1;

    // Mid-frame reset of the small instance while both syncs are active.
    found = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (x1 == 10'd19 && y1 == 10'd10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_19_10", 32'(found), 32'd1);
    check("pre_hs1",     32'(hs1),   32'd1);
    rst1_n = 1'b0;
    @(negedge clk);
    check("mr1_x",   32'(x1),   32'd24);
    check("mr1_y",   32'(y1),   32'd14);
    check("mr1_hs",  32'(hs1),  32'd0);
    check("mr1_vs",  32'(vs1),  32'd0);
    check("mr1_act", 32'(act1), 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;

    // Whole-frame measurements on the small instance over three frames.
    fs_seen = 0; f_cnt = 0; f_vs = 0; f_act = 0; f_ls = 0; f_vy = -1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (fs1) fs_seen++;
      if (fs_seen == 1) begin
        f_cnt++;
        if (vs1 == S_POL) begin
          f_vs++;
          if (f_vy < 0) f_vy = int'(y1);
        end
        if (act1) f_act++;
        if (ls1)  f_ls++;
      end
      if (fs_seen == 3) break;
    end
    check("f_seen",   32'(fs_seen), 32'd3);
    check("f_period", 32'(f_cnt),   32'd375);
    check("f_vs",     32'(f_vs),    32'd50);
    check("f_vy",     32'(f_vy),    32'd10);
    check("f_act",    32'(f_act),   32'd128);
    check("f_ls",     32'(f_ls),    32'd15);

`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fc_three", 32'(fc1), 32'd3);
    force dut1.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut1.frame_cnt_q;
    @(negedge clk);
    check("fc_forced", 32'(fc1), 32'd65535);
    found = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (fs1) begin
        found = 1'b1;
        break;
      end
    end
    check("fc_wrap_seen", 32'(found), 32'd1);
    check("fc_wrap",      32'(fc1),   32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
